// File: rtl/cdc_xfer_scheduler_pkg.sv
// cdc_xfer_scheduler_pkg: FSM encoding, default timing constants and a
// round-robin helper shared by the scheduler and its arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
package cdc_xfer_scheduler_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_TIMEOUT   = 255;

  // Index after idx in a ring of n requesters (wraps n-1 -> 0 even when n
  // is not a power of two).
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdc_xfer_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr_i.
// Latency: 0 cycles (pure logic). Backpressure: none; caller masks req_i.
// Ports: req_i request vector, ptr_i highest-priority index, gnt_o one-hot grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_xfer_scheduler.sv
// cdc_xfer_scheduler: round-robin scheduler driving a toggle-flag CDC handshake.
// Latency: grant in the request cycle; cdc_flag toggles SETUP_CYC cycles later; IDLE on echoed ack.
// Backpressure: one transfer in flight; req_ready is low outside IDLE, in FAULT and for one cycle after reset.
// Ports: req_valid/req_data/req_ready  requester side (valid-ready, one-hot ready)
//        cdc_data/cdc_flag/ack_flag    synchroniser side (toggle flag, synchronised echo)
//        grant_id/busy/timeout_err     status
module cdc_xfer_scheduler
  import cdc_xfer_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           cdc_data,
  output logic                       cdc_flag,
  input  logic                       ack_flag,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SCW = $clog2(SETUP_CYC + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYC - 1);
  localparam logic [TCW-1:0] WAIT_LIMIT = TCW'(TIMEOUT);

  state_t           state_q,     state_d;
  logic [SCW-1:0]   setup_cnt_q, setup_cnt_d;
  logic [TCW-1:0]   wait_cnt_q,  wait_cnt_d;
  logic [IDW-1:0]   ptr_q,       ptr_d;
  logic [WIDTH-1:0] data_q,      data_d;
  logic             flag_q,      flag_d;
  logic [IDW-1:0]   gid_q,       gid_d;
  logic             terr_q,      terr_d;
  // Low during reset and for the first cycle after release, so no grant can
  // be taken on the edge where aresetn rises.
  logic             arm_q;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [WIDTH-1:0]   sel_data;
  logic [IDW-1:0]     sel_idx;
  logic [IDW-1:0]     sel_next;
  logic               grant_vld;
  logic               ack_match;
  logic [TCW-1:0]     wait_inc;

  assign arb_req = req_valid & {NUM_REQ{(state_q == ST_IDLE) && arm_q}};

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IDW)
  ) u_rr_arbiter (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // One-hot grant -> payload, index and next round-robin start point.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    sel_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_idx  = IDW'(i);
        sel_next = IDW'(rr_next(i, NUM_REQ));
      end
    end
  end

  assign grant_vld = |arb_gnt;
  assign ack_match = (ack_flag == flag_q);
  // Saturating so a stuck count can never wrap back below the limit.
  assign wait_inc  = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + TCW'(1);

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    flag_d      = flag_q;
    gid_d       = gid_q;
    terr_d      = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          data_d      = sel_data;
          gid_d       = sel_idx;
          ptr_d       = sel_next;
          setup_cnt_d = '0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          flag_d      = ~flag_q;
          setup_cnt_d = '0;
          wait_cnt_d  = '0;
          state_d     = ST_WAIT;
        end else begin
          setup_cnt_d = setup_cnt_q + SCW'(1);
        end
      end
      ST_WAIT: begin
        // An ack arriving on the limit cycle wins over the timeout.
        if (ack_match) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == WAIT_LIMIT) begin
            terr_d  = 1'b1;
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (ack_match) begin
          terr_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      wait_cnt_q  <= '0;
      ptr_q       <= '0;
      data_q      <= '0;
      flag_q      <= 1'b0;
      gid_q       <= '0;
      terr_q      <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      flag_q      <= flag_d;
      gid_q       <= gid_d;
      terr_q      <= terr_d;
      arm_q       <= 1'b1;
    end
  end

  assign req_ready   = arb_gnt;
  assign cdc_data    = data_q;
  assign cdc_flag    = flag_q;
  assign grant_id    = gid_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// tb_cdc_xfer_scheduler: vector table, directed corner sequences and random
// transfers checked against a transfer-level round-robin/timing model.
// Latency: n/a. Backpressure: bench echoes the flag after a chosen delay.
module tb_cdc_xfer_scheduler;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int SC = 2;
  localparam int TO = 16;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic [W-1:0]      cdc_data;
  logic              cdc_flag;
  logic              ack_flag;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  always #5 aclk = ~aclk;

  cdc_xfer_scheduler #(
    .NUM_REQ   (NR),
    .WIDTH     (W),
    .SETUP_CYC (SC),
    .TIMEOUT   (TO)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cdc_data    (cdc_data),
    .cdc_flag    (cdc_flag),
    .ack_flag    (ack_flag),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  // Model: next round-robin start index and the flag value last sent.
  int   m_ptr  = 0;
  logic m_flag = 1'b0;

  typedef struct {
    logic [3:0] v;    // req_valid at grant time
    logic [3:0] vf;   // req_valid while the transfer is in flight
    logic [3:0] rdy;  // required one-hot req_ready
    int         dly;  // WAIT cycle on which the ack is echoed
  } vec_t;
  vec_t tbl[14];

  logic [3:0] v, vf;
  int         dly, gidx;
  logic [7:0] gdat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < NR; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Round-robin rule: first valid requester at or after m_ptr, circularly.
  function automatic logic [3:0] model_pick(input logic [3:0] vv);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (vv[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  task automatic check_flight(input int gi, input logic [7:0] gd);
    chk("flight_ready", 32'(req_ready),   32'd0);
    chk("flight_busy",  32'(busy),        32'd1);
    chk("flight_data",  32'(cdc_data),    32'(gd));
    chk("flight_gid",   32'(grant_id),    32'(gi));
    chk("flight_flag",  32'(cdc_flag),    32'(m_flag));
    chk("flight_err",   32'(timeout_err), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 32'(req_ready),   32'd0);
    chk("rst_data",  32'(cdc_data),    32'd0);
    chk("rst_flag",  32'(cdc_flag),    32'd0);
    chk("rst_gid",   32'(grant_id),    32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_err",   32'(timeout_err), 32'd0);
  endtask

  // Grant plus SETUP phase; returns at the first WAIT cycle, before the ack.
  task automatic grant_setup(input logic [3:0] gv, input logic [3:0] gvf,
                             input logic [3:0] exp_rdy, input logic [31:0] dat,
                             output int gi, output logic [7:0] gd);
    req_valid = gv;
    req_data  = dat;
    #1;
    chk("grant_ready", 32'(req_ready), 32'(exp_rdy));
    chk("grant_busy",  32'(busy),      32'd0);
    gi    = oh2idx(exp_rdy);
    gd    = dat[gi*8 +: 8];
    m_ptr = (gi + 1) % NR;
    cyc();
    // New payloads after consumption must not leak into cdc_data.
    req_valid = gvf;
    req_data  = $urandom;
    for (int k = 0; k < SC; k++) begin
      #1;
      check_flight(gi, gd);
      cyc();
    end
    m_flag = ~m_flag;
  endtask

  task automatic xfer(input logic [3:0] xv, input logic [3:0] xvf,
                      input logic [3:0] exp_rdy, input logic [31:0] dat,
                      input int adly);
    int         gi;
    logic [7:0] gd;
    grant_setup(xv, xvf, exp_rdy, dat, gi, gd);
    for (int w = 1; w <= adly; w++) begin
      if (w == adly) ack_flag = m_flag;
      #1;
      check_flight(gi, gd);
      cyc();
    end
    #1;
    chk("ack_idle", 32'(busy),        32'd0);
    chk("ack_err",  32'(timeout_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fairness then withdrawal / wrap vectors; expected grants derived by hand.
    tbl[0]  = '{4'b1111, 4'b1111, 4'b0001, 1};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0010, 2};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0100, 3};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1000, 4};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b0001, 5};
    tbl[5]  = '{4'b1111, 4'b1111, 4'b0010, 6};
    tbl[6]  = '{4'b1111, 4'b1111, 4'b0100, 7};
    tbl[7]  = '{4'b1111, 4'b1111, 4'b1000, TO};
    tbl[8]  = '{4'b0110, 4'b1000, 4'b0010, 4};
    tbl[9]  = '{4'b1000, 4'b0000, 4'b1000, 2};
    tbl[10] = '{4'b0100, 4'b0000, 4'b0100, 3};
    tbl[11] = '{4'b0011, 4'b0000, 4'b0001, 5};
    tbl[12] = '{4'b1010, 4'b0000, 4'b0010, 7};
    tbl[13] = '{4'b1001, 4'b0000, 4'b1000, 1};

    aresetn   = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    ack_flag  = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    #1;
    check_reset_outputs();
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("release_no_grant", 32'(req_ready), 32'd0);
    cyc();

    for (int i = 0; i < 14; i++)
      xfer(tbl[i].v, tbl[i].vf, tbl[i].rdy, $urandom, tbl[i].dly);

    // Single transfer: A5 from requester 0, ack 6 cycles after the toggle.
    xfer(4'b0001, 4'b0000, 4'b0001, 32'h3C5A_96A5, 6);

    // Randomised traffic, including idle gaps and the ack-on-limit boundary.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 4'b0000;
        #1;
        chk("rand_idle_ready", 32'(req_ready), 32'd0);
        chk("rand_idle_busy",  32'(busy),      32'd0);
        cyc();
      end
      v   = 4'($urandom_range(1, 15));
      vf  = 4'($urandom_range(0, 15));
      dly = int'($urandom_range(1, TO));
      xfer(v, vf, model_pick(v), $urandom, dly);
    end

    // Timeout: no ack for TO WAIT cycles, then FAULT blocks grants until ack.
    grant_setup(4'b1111, 4'b1111, model_pick(4'b1111), $urandom, gidx, gdat);
    for (int w = 1; w <= TO; w++) begin
      #1;
      check_flight(gidx, gdat);
      cyc();
    end
    #1;
    chk("timeout_err_set",  32'(timeout_err), 32'd1);
    chk("timeout_busy",     32'(busy),        32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      chk("fault_no_grant", 32'(req_ready),   32'd0);
      chk("fault_err_held", 32'(timeout_err), 32'd1);
    end
    cyc();
    ack_flag = m_flag;
    #1;
    chk("fault_err_before_ack_edge", 32'(timeout_err), 32'd1);
    cyc();
    #1;
    chk("fault_exit_err", 32'(timeout_err), 32'd0);
    chk("fault_exit_idle", 32'(busy),       32'd0);

    // Ack on exactly the timeout cycle: IDLE, no fault.
    xfer(4'b0110, 4'b0000, model_pick(4'b0110), $urandom, TO);

    // Reset while in WAIT, held for 3 cycles.
    grant_setup(4'b1111, 4'b1111, model_pick(4'b1111), $urandom, gidx, gdat);
    cyc();
    cyc();
    aresetn = 1'b0;
    #1;
    check_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("rst_hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge aclk);
    aresetn  = 1'b1;
    ack_flag = 1'b0;
    m_flag   = 1'b0;
    m_ptr    = 0;
    #1;
    chk("rst_release_no_grant", 32'(req_ready), 32'd0);
    cyc();
    xfer(4'b1111, 4'b0000, 4'b0001, $urandom, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
